// File: rtl/uart_rx_16x.sv
// ---------------------------------------------------------------------------
// uart_rx_16x
//
// UART receiver driven by a 16x-baud oversample strobe. The asynchronous
// serial line is synchronised through two flops. A falling edge is then
// qualified as a start bit by a mid-bit check. Each data bit is sampled
// 16 ticks after the previous sample, which is near mid-bit. The stop bit
// decides between delivering the byte and flagging a framing error.
//
// Frame format: one start bit (low), DATA_BITS data bits sent LSB first,
// no parity, and one stop bit (high).
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous, active-high reset
//   i_os_tick    16x-baud strobe, one i_clk cycle wide
//   i_rx         asynchronous serial input, idle high
//   o_rx_data    last correctly framed word
//   o_rx_valid   one-cycle pulse; o_rx_data has just been updated
//   o_frame_err  one-cycle pulse; the stop bit was sampled low
//   o_busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_16x #(
    parameter int DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_os_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

    // Two-flop synchroniser. Both flops reset to the idle level, so that
    // reset cannot manufacture a start edge.
    logic r_rx_p0;
    logic r_rx_p1;
    logic w_rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_p0 <= 1'b1;
            r_rx_p1 <= 1'b1;
        end else begin
            r_rx_p0 <= i_rx;
            r_rx_p1 <= r_rx_p0;
        end
    end

    assign w_rx_s = r_rx_p1;

    // Frame state and counters.
    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_tick_cnt;
    logic [3:0]           w_tick_nxt;
    logic [2:0]           r_bit_cnt;
    logic [2:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_shift_en;
    logic                 w_load;
    logic                 w_ferr;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control. Nothing advances except on a tick
    // cycle. Outside tick cycles every default below simply holds the
    // current value.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;

        if (i_os_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = 4'd0;
                    end
                end

                S_START: begin
                    if (r_tick_cnt == MID_START) begin
                        if (!w_rx_s) begin
                            w_state_nxt = S_DATA;
                            w_tick_nxt  = 4'd0;
                            w_bit_nxt   = 3'd0;
                        end else begin
                            // The line came back high before mid-bit. Treat
                            // it as a glitch and report nothing.
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 4'd1;
                    end
                end

                S_DATA: begin
                    // The counter wraps 15->0 by itself, so the next sample
                    // point is exactly 16 ticks later.
                    w_tick_nxt = r_tick_cnt + 4'd1;
                    if (r_tick_cnt == LAST_TICK) begin
                        w_shift_en = 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_nxt = S_STOP;
                            w_tick_nxt  = 4'd0;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 3'd1;
                        end
                    end
                end

                S_STOP: begin
                    w_tick_nxt = r_tick_cnt + 4'd1;
                    if (r_tick_cnt == LAST_TICK) begin
                        if (w_rx_s) begin
                            // Return to idle at mid-stop. A start bit that
                            // follows the stop bit directly is then caught.
                            w_load      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr      = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    // Wait for the line to go high again. A held-low line
                    // therefore yields a single error and no false start.
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt  <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;

            // Bits enter at the MSB end. After DATA_BITS shifts, the first
            // bit received (the LSB) has reached bit 0.
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end

            if (w_load) begin
                r_rx_data <= r_shift;
            end

            // Ticks are never back to back, so each of these pulses lasts
            // exactly one clock. w_load and w_ferr are exclusive.
            r_rx_valid  <= w_load;
            r_frame_err <= w_ferr;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_16x.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_16x
//
// Directed bench for uart_rx_16x. The oversample tick is generated every
// TICK_DIV clocks, which gives a bit period of 16*TICK_DIV clocks and keeps
// the run short. A monitor logs every output pulse. The main sequence
// drives frames and checks its expectations against that log.
// ---------------------------------------------------------------------------
module tb_uart_rx_16x;

    localparam int TICK_DIV = 4;
    localparam int BIT      = 16 * TICK_DIV;

    logic       clk;
    logic       rst;
    logic       os_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_16x #(.DATA_BITS(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_os_tick   (os_tick),
        .i_rx        (rx),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick generator: one-cycle strobe every TICK_DIV clocks, updated on the
    // falling edge.
    int tdiv = 0;
    initial os_tick = 1'b0;
    always @(negedge clk) begin
        tdiv    <= (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
        os_tick <= (tdiv == TICK_DIV - 1);
    end

    // Output monitor.
    int         cyc         = 0;
    int         n_valid     = 0;
    int         n_ferr      = 0;
    int         n_both      = 0;
    int         n_busy_rise = 0;
    int         n_bad_chg   = 0;
    logic       busy_q      = 1'b0;
    logic       rst_q       = 1'b0;
    logic [7:0] data_q      = 8'h00;
    logic [7:0] data_log [16];
    int         time_log [16];

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        busy_q <= busy;
        data_q <= rx_data;
        if (rx_valid) begin
            if (n_valid < 16) begin
                data_log[n_valid] <= rx_data;
                time_log[n_valid] <= cyc;
            end
            n_valid <= n_valid + 1;
        end
        if (frame_err)             n_ferr      <= n_ferr + 1;
        if (rx_valid && frame_err) n_both      <= n_both + 1;
        if (busy && !busy_q)       n_busy_rise <= n_busy_rise + 1;
        if (rx_data !== data_q && !rx_valid && !rst_q) n_bad_chg <= n_bad_chg + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    int v0, f0, b0;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_data",  32'(rx_data),   32'h00);
        check("rst_valid", 32'(rx_valid),  32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        idle_bits(1);

        // Single frame 0x55
        send_frame(8'h55, 1'b1);
        idle_bits(2);
        check("single_cnt",  32'(n_valid),     32'd1);
        check("single_log",  32'(data_log[0]), 32'h55);
        check("single_data", 32'(rx_data),     32'h55);
        check("single_ferr", 32'(n_ferr),      32'd0);
        check("single_busy", 32'(busy),        32'h0);

        // Back-to-back 0xA5, 0x3C with no idle gap
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle_bits(2);
        check("b2b_cnt",     32'(n_valid),                  32'd3);
        check("b2b_first",   32'(data_log[1]),              32'hA5);
        check("b2b_second",  32'(data_log[2]),              32'h3C);
        check("b2b_spacing", 32'(time_log[2] - time_log[1]), 32'(10 * BIT));
        check("b2b_ferr",    32'(n_ferr),                   32'd0);

        // Glitch: low for 3 ticks, then high
        b0 = n_busy_rise;
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        idle_bits(2);
        check("glitch_valid", 32'(n_valid),         32'd3);
        check("glitch_ferr",  32'(n_ferr),          32'd0);
        check("glitch_busyp", 32'(n_busy_rise - b0), 32'd1);
        check("glitch_busy",  32'(busy),            32'h0);
        check("glitch_data",  32'(rx_data),         32'h3C);

        // Framing error after a good 0x55
        send_frame(8'h55, 1'b1);
        send_frame(8'hFF, 1'b0);
        idle_bits(2);
        check("ferr_valid", 32'(n_valid),     32'd4);
        check("ferr_log",   32'(data_log[3]), 32'h55);
        check("ferr_cnt",   32'(n_ferr),      32'd1);
        check("ferr_data",  32'(rx_data),     32'h55);
        check("ferr_busy",  32'(busy),        32'h0);

        // Break: held low for 20 bits, released, then 0x81
        rx = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        idle_bits(2);
        check("brk_ferr",  32'(n_ferr),  32'd2);
        check("brk_valid", 32'(n_valid), 32'd4);
        send_frame(8'h81, 1'b1);
        idle_bits(2);
        check("brk_cnt",  32'(n_valid), 32'd5);
        check("brk_data", 32'(rx_data), 32'h81);
        check("brk_ferr2", 32'(n_ferr), 32'd2);

        // Reset in the middle of data bit 4 of 0xF0
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_data",  32'(rx_data),   32'h00);
        check("abort_valid", 32'(rx_valid),  32'h0);
        check("abort_ferr",  32'(frame_err), 32'h0);
        check("abort_busy",  32'(busy),      32'h0);
        idle_bits(5);
        check("abort_nov", 32'(n_valid - v0), 32'd0);
        check("abort_nof", 32'(n_ferr - f0),  32'd0);
        send_frame(8'h0F, 1'b1);
        idle_bits(2);
        check("post_cnt",  32'(n_valid),     32'(v0 + 1));
        check("post_log",  32'(data_log[5]), 32'h0F);
        check("post_data", 32'(rx_data),     32'h0F);

        // Global properties
        check("never_both",    32'(n_both),    32'd0);
        check("data_stable",   32'(n_bad_chg), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_16x.md
# uart_rx_16x

UART receiver for the serial link, consuming the 16x oversampling tick from the baud-rate generator. At 100 MHz clock and 9600 baud, that tick is a one-cycle pulse every 651 clocks. The block synchronises the asynchronous `rx` line, detects and validates the start bit, and samples each data bit at mid-bit. It then checks the stop bit and presents the received byte with a one-cycle valid pulse, or a one-cycle framing-error pulse.

## Interface
- `DATA_BITS`, default 8: data bits per frame (5..8); LSB first, no parity, one stop bit.
- `clk`  input  1: system clock; one clock for the whole block.
- `rst`  input  1: reset, synchronous and active-high.
- `os_tick`  input  1: 16x-baud oversample strobe, one `clk` cycle wide.
- `rx`  input  1: asynchronous serial line, idle high.
- `rx_data`  output  DATA_BITS: last correctly framed byte.
- `rx_valid`  output  1: one-cycle pulse; `rx_data` updated.
- `frame_err`  output  1: one-cycle pulse; stop bit sampled low.
- `busy`  output  1: high in any state other than IDLE.

## Operation
- **Synchroniser.** Two flops on `rx` produce `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Counters.** `tick_cnt` is 4-bit and wraps 15->0. `bit_cnt` is 3-bit.
- **Tick gating.** State, counters and sampling advance only on `clk` edges where `os_tick`=1. On all other cycles they hold.
- **IDLE.**
  - If `rx_s`=0 at a tick -> START, `tick_cnt`<=0.
- **START.** Increment `tick_cnt` each tick. At the tick where `tick_cnt`==7 (mid start bit):
  - `rx_s`=0 -> DATA, `tick_cnt`<=0, `bit_cnt`<=0.
  - `rx_s`=1 -> false start; return to IDLE with no output pulse.
- **DATA.** At the tick where `tick_cnt`==15, shift `rx_s` into the shift register at the MSB end, so the LSB arrives first and is finally in bit 0.
  - If `bit_cnt`==DATA_BITS-1 -> STOP, `tick_cnt`<=0.
  - Otherwise `bit_cnt`++.
- **STOP.** At the tick where `tick_cnt`==15:
  - `rx_s`=1 -> load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - `rx_s`=0 -> pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
- **BREAK.**
  - If `rx_s`=1 at a tick -> IDLE.
  - A held-low line therefore produces exactly one `frame_err` and never a spurious start.
- **Priority.** `rx_valid` and `frame_err` are never high together.
- **Reset.** `rst` overrides everything, including mid-frame. The partial frame is discarded with no pulse.
- **Reset values.**
  - State = IDLE.
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0.
  - `tick_cnt`=0, `bit_cnt`=0, shift register=0.
  - Synchroniser flops = 1.

## Timing
- **Input latency.** `rx` to `rx_s` is 2 `clk` cycles. Start detection occurs at the first tick after `rx_s` falls, i.e. 0..1 tick of uncertainty.
- **Sample points.**
  - Start bit: sampled 8 ticks after detection.
  - Each data bit and the stop bit: sampled 16 ticks after the previous sample, i.e. near mid-bit.
- **Output registration.** `rx_valid`/`frame_err` are registered. Each goes high in the `clk` cycle immediately after the tick edge that sampled the stop bit, for exactly one `clk` cycle.
- **Data timing.** `rx_data` changes on the same edge that raises `rx_valid`, and is stable until the next `rx_valid`.
- **Frame latency.** From detection to `rx_valid` is 8 + 16·DATA_BITS + 16 ticks; 152 ticks for 8 bits.
- **Back-to-back frames.** The block returns to IDLE at the mid-stop sample, so a start bit immediately following the stop bit is detected. There is no dead time beyond half a bit.
- **`busy`.** Registered from state: high from the edge entering START to the edge returning to IDLE.
- **`os_tick` assumption.** `os_tick` is never high on consecutive cycles. No behaviour is defined for a tick on consecutive cycles.

## Test plan
- **Single frame.** 9600 baud, `os_tick` every 651 clocks, 10416-clock bits; send 0x55. -> One `rx_valid` pulse, `rx_data`=0x55, `frame_err` stays 0, `busy` low afterwards.
- **Back-to-back frames.** Send 0xA5 then 0x3C with no idle gap. -> Two `rx_valid` pulses ~10 bit times apart, data 0xA5 then 0x3C.
- **Glitch rejection.** `rx` low for 3 ticks, then high. -> No `rx_valid`/`frame_err`; `busy` pulses and returns low at the mid-start check.
- **Framing error.** Receive 0x55 correctly, then send 0xFF with the stop bit forced low. -> One `frame_err` pulse, `rx_valid` 0, `rx_data` still 0x55.
- **Break recovery.** Hold `rx` low for 20 bit times, release, then send 0x81. -> Exactly one `frame_err`, then `rx_valid` with `rx_data`=0x81.
- **Reset mid-frame.** Assert `rst` for one cycle during data bit 4 of 0xF0, then send 0x0F. -> Immediately after reset all outputs read 0, no pulse occurs for the aborted frame, then `rx_valid` fires with `rx_data`=0x0F.
